// File: rtl/shift_link_pkg.sv
// Shared types and default sizes for the serial shift-link sequencer.
// No logic; holds the controller state encoding and default geometry.
// Imported by every file of the shift-link block.
package shift_link_pkg;

    // Transmit-side controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default word width and external shift-chain depth.
    localparam int SL_WIDTH = 8;
    localparam int SL_DEPTH = 4;

endpackage

// File: rtl/tag_delay.sv
// (DEPTH+1)-stage single-bit delay line marking which chain slots carry live bits.
// Latency: stage 0 is tag_in registered once; stage k lags it by k more cycles.
// No backpressure: shifts every cycle, cleared by synchronous reset.
module tag_delay #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tag_in,
    output logic [DEPTH:0]   tags
);

    // Advance every tag one stage per cycle, new tag enters stage 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tags <= '0;
        end else begin
            tags <= {tags[DEPTH-1:0], tag_in};
        end
    end

endmodule

// File: rtl/shift_link_ctrl.sv
// Serializes a parallel word MSB-first into an external shift chain and rebuilds it from the chain output.
// Latency: accept to outValid is WIDTH+DEPTH+1 cycles; one word per WIDTH+1 cycles.
// Backpressure: inReady is low while a word is shifting out; there is no output-side backpressure.
module shift_link_ctrl
    import shift_link_pkg::*;
#(
    parameter int WIDTH = SL_WIDTH,
    parameter int DEPTH = SL_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic             serOut,
    input  logic             serIn,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] tx;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx;
    logic [CW-1:0]    rx_cnt;
    logic [DEPTH:0]   tags;

    logic accept;
    logic shift_more;
    logic tag_in;
    logic rx_take;
    logic rx_done;

    assign inReady    = (state == IDLE);
    assign accept     = inValid & inReady;
    // bit_cnt holds the index of the bit currently on serOut.
    assign shift_more = (state == SHIFT) && (bit_cnt != LAST_BIT);
    // Stage 0 of the tag line must match whatever serOut will carry next cycle.
    assign tag_in     = accept | shift_more;
    // The last tag stage lines up with the chain output.
    assign rx_take    = tags[DEPTH];
    assign rx_done    = rx_take && (rx_cnt == LAST_BIT);
    assign busy       = (state == SHIFT) | (|tags) | (rx_cnt != '0);

    tag_delay #(
        .DEPTH (DEPTH)
    ) u_tag_delay (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tags   (tags)
    );

    // Transmit FSM: latch the word on accept and present one bit per cycle, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= '0;
            bit_cnt <= '0;
            serOut  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        serOut  <= inData[WIDTH-1];
                        tx      <= inData << 1;
                        bit_cnt <= '0;
                    end else begin
                        serOut  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_more) begin
                        serOut  <= tx[WIDTH-1];
                        tx      <= tx << 1;
                        bit_cnt <= bit_cnt + CW'(1);
                    end else begin
                        state   <= IDLE;
                        serOut  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    serOut <= 1'b0;
                end
            endcase
        end
    end

    // Receive side: collect tagged chain bits and publish the word when the last one arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx       <= '0;
            rx_cnt   <= '0;
            outData  <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= 1'b0;
            if (rx_take) begin
                rx <= {rx[WIDTH-2:0], serIn};
                if (rx_done) begin
                    outData  <= {rx[WIDTH-2:0], serIn};
                    outValid <= 1'b1;
                    rx_cnt   <= '0;
                end else begin
                    rx_cnt   <= rx_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_link_ctrl.sv
// Directed bench for shift_link_ctrl with a behavioural shift chain in the loop.
// Three instances: defaults (8/4), minimum (2/1) and maximum (32/16).
// Inputs driven and outputs sampled on the falling edge.
module tb_shift_link_ctrl;

    localparam int W0 = 8;
    localparam int D0 = 4;
    localparam int W1 = 2;
    localparam int D1 = 1;
    localparam int W2 = 32;
    localparam int D2 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [W0-1:0] in_data0 = '0;
    logic          in_valid0 = 1'b0;
    logic          in_ready0, ser_out0, ser_in0, out_valid0, busy0;
    logic [W0-1:0] out_data0;
    logic [D0-1:0] chain0 = '0;

    logic [W1-1:0] in_data1 = '0;
    logic          in_valid1 = 1'b0;
    logic          in_ready1, ser_out1, ser_in1, out_valid1, busy1;
    logic [W1-1:0] out_data1;
    logic [D1-1:0] chain1 = '0;

    logic [W2-1:0] in_data2 = '0;
    logic          in_valid2 = 1'b0;
    logic          in_ready2, ser_out2, ser_in2, out_valid2, busy2;
    logic [W2-1:0] out_data2;
    logic [D2-1:0] chain2 = '0;

    assign ser_in0 = chain0[D0-1];
    assign ser_in1 = chain1[D1-1];
    assign ser_in2 = chain2[D2-1];

    int          acc_t0[$];
    int          acc_t1[$];
    int          acc_t2[$];
    int          pv_t0[$];
    int          pv_t1[$];
    int          pv_t2[$];
    logic [31:0] pv_d0[$];
    logic [31:0] pv_d1[$];
    logic [31:0] pv_d2[$];

    shift_link_ctrl #(.WIDTH(W0), .DEPTH(D0)) u_dut0 (
        .clk(clk), .rst(rst), .inData(in_data0), .inValid(in_valid0), .inReady(in_ready0),
        .serOut(ser_out0), .serIn(ser_in0), .outData(out_data0), .outValid(out_valid0), .busy(busy0));

    shift_link_ctrl #(.WIDTH(W1), .DEPTH(D1)) u_dut1 (
        .clk(clk), .rst(rst), .inData(in_data1), .inValid(in_valid1), .inReady(in_ready1),
        .serOut(ser_out1), .serIn(ser_in1), .outData(out_data1), .outValid(out_valid1), .busy(busy1));

    shift_link_ctrl #(.WIDTH(W2), .DEPTH(D2)) u_dut2 (
        .clk(clk), .rst(rst), .inData(in_data2), .inValid(in_valid2), .inReady(in_ready2),
        .serOut(ser_out2), .serIn(ser_in2), .outData(out_data2), .outValid(out_valid2), .busy(busy2));

    // Cycle counter, external shift chains and handshake log (cycle during which the accept happened).
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        chain0 <= (chain0 << 1) | D0'(ser_out0);
        chain1 <= (chain1 << 1) | D1'(ser_out1);
        chain2 <= (chain2 << 1) | D2'(ser_out2);
        if (!rst && in_valid0 && in_ready0) acc_t0.push_back(cyc);
        if (!rst && in_valid1 && in_ready1) acc_t1.push_back(cyc);
        if (!rst && in_valid2 && in_ready2) acc_t2.push_back(cyc);
    end

    // Output pulse log.
    always @(negedge clk) begin
        if (out_valid0) begin pv_t0.push_back(cyc); pv_d0.push_back(32'(out_data0)); end
        if (out_valid1) begin pv_t1.push_back(cyc); pv_d1.push_back(32'(out_data1)); end
        if (out_valid2) begin pv_t2.push_back(cyc); pv_d2.push_back(32'(out_data2)); end
    end

    task automatic clear_logs();
        acc_t0.delete(); pv_t0.delete(); pv_d0.delete();
        acc_t1.delete(); pv_t1.delete(); pv_d1.delete();
        acc_t2.delete(); pv_t2.delete(); pv_d2.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
        checks++; if (ser_out0 !== 1'b0) begin errors++; $display("FAIL reset_ser_out: got %b want 0", ser_out0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
        checks++; if (out_data0 !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if ({busy1, busy2, in_ready1, in_ready2} !== 4'b0011) begin
            errors++; $display("FAIL reset_sweep_insts: got %b want 0011", {busy1, busy2, in_ready1, in_ready2});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", in_ready0, busy0);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++; if (ser_out0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL idle_cycle%0d: got ser=%b vld=%b busy=%b want 0 0 0", i, ser_out0, out_valid0, busy0);
            end
        end
    endtask

    task automatic test_single_word();
        int         t;
        logic [7:0] w;
        w = 8'hA5;
        clear_logs();
        @(negedge clk);
        t = cyc; in_data0 = w; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (ser_out0 !== w[7-k]) begin errors++; $display("FAIL single_ser_bit%0d: got %b want %b", k, ser_out0, w[7-k]); end
            checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL single_ready_low%0d: got %b want 0", k, in_ready0); end
            @(negedge clk);
        end
        checks++; if (in_ready0 !== 1'b1 || ser_out0 !== 1'b0) begin
            errors++; $display("FAIL single_ready_back: got ready=%b ser=%b want 1 0", in_ready0, ser_out0);
        end
        while (cyc < t + 13) begin
            checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_early_valid@%0d: got 1 want 0", cyc - t); end
            @(negedge clk);
        end
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL single_valid_t13: got %b want 1", out_valid0); end
        checks++; if (out_data0 !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data0); end
        @(negedge clk);
        checks++; if (busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
            errors++; $display("FAIL single_after: got busy=%b vld=%b want 0 0", busy0, out_valid0);
        end
        checks++; if (out_data0 !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h want a5", out_data0); end
    endtask

    task automatic test_back_to_back();
        int t;
        clear_logs();
        @(negedge clk);
        t = cyc; in_data0 = 8'h3C; in_valid0 = 1'b1;
        @(negedge clk);
        in_data0 = 8'hC3;
        repeat (8) @(negedge clk);
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_t9: got %b want 1", in_ready0); end
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (25) @(negedge clk);
        checks++; if (acc_t0.size() != 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_t0.size()); end
        else begin
            checks++; if (acc_t0[1] - t != 9) begin errors++; $display("FAIL b2b_second_accept: got t+%0d want t+9", acc_t0[1] - t); end
        end
        checks++; if (pv_t0.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pv_t0.size()); end
        else begin
            checks++; if (pv_t0[0] - t != 13 || pv_d0[0] !== 32'h3C) begin
                errors++; $display("FAIL b2b_word0: got t+%0d %h want t+13 3c", pv_t0[0] - t, pv_d0[0]);
            end
            checks++; if (pv_t0[1] - t != 22 || pv_d0[1] !== 32'hC3) begin
                errors++; $display("FAIL b2b_word1: got t+%0d %h want t+22 c3", pv_t0[1] - t, pv_d0[1]);
            end
        end
    endtask

    task automatic test_handshake_hold();
        int t;
        clear_logs();
        @(negedge clk);
        t = cyc; in_data0 = 8'h11; in_valid0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            in_data0 = 8'(8'h20 + i);
            checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL hold_ready_low%0d: got %b want 0", i, in_ready0); end
        end
        @(negedge clk);
        in_data0 = 8'h5A;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (25) @(negedge clk);
        checks++; if (acc_t0.size() != 2) begin errors++; $display("FAIL hold_accepts: got %0d want 2", acc_t0.size()); end
        checks++; if (pv_d0.size() != 2) begin errors++; $display("FAIL hold_pulses: got %0d want 2", pv_d0.size()); end
        else begin
            checks++; if (pv_d0[0] !== 32'h11 || pv_d0[1] !== 32'h5A) begin
                errors++; $display("FAIL hold_words: got %h %h want 11 5a", pv_d0[0], pv_d0[1]);
            end
            checks++; if (pv_t0[0] - t != 13 || pv_t0[1] - t != 22) begin
                errors++; $display("FAIL hold_timing: got t+%0d t+%0d want t+13 t+22", pv_t0[0] - t, pv_t0[1] - t);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int t;
        int t2;
        clear_logs();
        @(negedge clk);
        t = cyc; in_data0 = 8'hFF; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        while (cyc < t + 5) @(negedge clk);
        checks++; if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
            errors++; $display("FAIL midrst_pre: got busy=%b ready=%b want 1 0", busy0, in_ready0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready0 !== 1'b1 || ser_out0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || out_data0 !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs: got rdy=%b ser=%b vld=%b busy=%b data=%h want 1 0 0 0 00",
                               in_ready0, ser_out0, out_valid0, busy0, out_data0);
        end
        @(negedge clk);
        t2 = cyc; in_data0 = 8'h01; in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (25) @(negedge clk);
        checks++; if (pv_d0.size() != 1) begin errors++; $display("FAIL midrst_pulses: got %0d want 1", pv_d0.size()); end
        else begin
            checks++; if (pv_d0[0] !== 32'h01) begin errors++; $display("FAIL midrst_word: got %h want 01", pv_d0[0]); end
            checks++; if (pv_t0[0] - t2 != 13) begin errors++; $display("FAIL midrst_latency: got %0d want 13", pv_t0[0] - t2); end
        end
    endtask

    task automatic test_param_sweep();
        logic [31:0] w1 [6];
        logic [31:0] w2 [4];
        int          idx;
        clear_logs();
        for (int i = 0; i < 6; i++) w1[i] = 32'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) w2[i] = $urandom;

        @(negedge clk);
        idx = 0; in_data1 = W1'(w1[0]); in_valid1 = 1'b1;
        for (int c = 0; c < 500 && idx < 6; c++) begin
            @(negedge clk);
            if (acc_t1.size() > idx) begin
                idx++;
                if (idx < 6) in_data1 = W1'(w1[idx]); else in_valid1 = 1'b0;
            end
        end
        in_valid1 = 1'b0;
        checks++; if (idx != 6) begin errors++; $display("FAIL sweep2_timeout: got %0d accepts want 6", idx); end
        repeat (W1 + D1 + 4) @(negedge clk);
        checks++; if (pv_d1.size() != 6) begin errors++; $display("FAIL sweep2_count: got %0d want 6", pv_d1.size()); end
        for (int i = 0; i < 6 && i < pv_d1.size() && i < acc_t1.size(); i++) begin
            checks++; if (pv_d1[i] !== w1[i]) begin errors++; $display("FAIL sweep2_word%0d: got %h want %h", i, pv_d1[i], w1[i]); end
            checks++; if (pv_t1[i] - acc_t1[i] != W1 + D1 + 1) begin
                errors++; $display("FAIL sweep2_lat%0d: got %0d want %0d", i, pv_t1[i] - acc_t1[i], W1 + D1 + 1);
            end
        end

        @(negedge clk);
        idx = 0; in_data2 = w2[0]; in_valid2 = 1'b1;
        for (int c = 0; c < 1000 && idx < 4; c++) begin
            @(negedge clk);
            if (acc_t2.size() > idx) begin
                idx++;
                if (idx < 4) in_data2 = w2[idx]; else in_valid2 = 1'b0;
            end
        end
        in_valid2 = 1'b0;
        checks++; if (idx != 4) begin errors++; $display("FAIL sweep32_timeout: got %0d accepts want 4", idx); end
        repeat (W2 + D2 + 4) @(negedge clk);
        checks++; if (pv_d2.size() != 4) begin errors++; $display("FAIL sweep32_count: got %0d want 4", pv_d2.size()); end
        for (int i = 0; i < 4 && i < pv_d2.size() && i < acc_t2.size(); i++) begin
            checks++; if (pv_d2[i] !== w2[i]) begin errors++; $display("FAIL sweep32_word%0d: got %h want %h", i, pv_d2[i], w2[i]); end
            checks++; if (pv_t2[i] - acc_t2[i] != W2 + D2 + 1) begin
                errors++; $display("FAIL sweep32_lat%0d: got %0d want %0d", i, pv_t2[i] - acc_t2[i], W2 + D2 + 1);
            end
        end
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL sweep_drained: got busy1=%b busy2=%b want 0 0", busy1, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_word();
        test_back_to_back();
        test_handshake_hold();
        test_reset_mid_word();
        test_param_sweep();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/shift_link_ctrl.md
# shift_link_ctrl

Sequencer for the 4-stage serial shift-register datapath. Accepts a parallel word over a valid/ready handshake and serializes it MSB-first onto the shift chain's `dataIn`. It tracks each bit through the chain with an internal tag pipeline, reassembles the word from the chain's `dataOut`, and presents it with a one-cycle `outValid` pulse. Sits between a parallel producer/consumer and the shift-register instance; used for link bring-up and loopback checking.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `DEPTH`, default 4: number of flop stages in the attached shift chain; legal range 1..16.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inData`  in  WIDTH  parallel word to send.
- `inValid`  in  1  `inData` is valid.
- `inReady`  out  1  controller can accept a word; transfer occurs when `inValid & inReady` at a rising edge.
- `serOut`  out  1  registered serial bit; drives the shift chain's `dataIn`.
- `serIn`  in  1  connected to the shift chain's `dataOut`.
- `outData`  out  WIDTH  reassembled word.
- `outValid`  out  1  one-cycle pulse: `outData` holds a new word.
- `busy`  out  1  a word is shifting out, or tagged bits are still in the chain.

## Operation
- **States:** IDLE and SHIFT.
  - IDLE: `inReady`=1 and `serOut`=0. On accept, latch `inData` into the tx register, clear the bit counter, and go to SHIFT.
  - SHIFT: `inReady`=0. Each cycle, drive the next tx bit, MSB first, on `serOut` and inject tag=1 into the tag pipeline. After WIDTH bits, return to IDLE.
- **Idle cycles:** inject tag=0 and `serOut`=0.
- **Tag pipeline:** DEPTH+1 stages. Stage 0 aligns with `serOut`; stages 1..DEPTH mirror the external chain. When the last stage is 1, shift `serIn` into the rx register LSB-side (`rx <= {rx[WIDTH-2:0], serIn}`) and increment the rx counter.
- **Word completion:** when the rx counter reaches WIDTH, copy rx to `outData`, pulse `outValid`, and clear the counter.
- **Hold:** `outData` holds its value until the next `outValid`.
- **Throughput:** one word per WIDTH+1 cycles. There is a mandatory one-cycle IDLE gap between words. A new word may enter while the previous word's bits are still draining; tags keep the words separated.
- **Busy:** `busy` = (state==SHIFT) | (OR of all tag stages) | (rx counter ≠ 0).
- **Counters:** the bit counter and rx counter are each `$clog2(WIDTH+1)` bits wide. Both saturate by construction; no wrap beyond WIDTH.
- **Reset:**
  - Values after reset: state=IDLE, `serOut`=0, `inReady`=1, `outValid`=0, `outData`=0, `busy`=0, and all tags, counters and the rx register cleared.
- **Reset mid-word:**
  - The word is abandoned and no `outValid` is produced for it.
  - Bits already inside the external chain are untagged and ignored.
  - Accepts after reset behave normally.
- **`inValid` while not ready:** ignored; the word is held by the producer.

## Timing
- **Accept at edge t:** bit k (k=0 is the MSB) appears on `serOut` during cycle t+1+k, for k = 0..WIDTH-1.
- **Chain alignment:** bit k appears on `serIn` during cycle t+1+k+DEPTH and is sampled at the end of that cycle.
- **Output:** `outValid` is high during cycle t+WIDTH+DEPTH+1. Latency from accept to `outValid` is WIDTH+DEPTH+1 cycles; for defaults, 13.
- **Ready:** `inReady` is low during cycles t+1..t+WIDTH and high again in cycle t+WIDTH+1.
- **Combinational paths:** none from inputs to outputs; every output is registered except `inReady` and `busy`, which are decoded from registered state.

## Structure
- Shared package `shift_link_pkg`:
  - state enum {IDLE, SHIFT};
  - default constants `SL_WIDTH`=8 and `SL_DEPTH`=4.
- Sub-module `tag_delay`: a parameterised (DEPTH+1)-stage single-bit delay line with synchronous reset.
- The shift chain itself is instantiated by the parent, not inside this block. The bench connects the existing 4-stage shift register between `serOut` and `serIn`.

## Test plan
- **Single word:** after reset, send `inData`=0xA5 for one handshake. Expect `serOut` sequence 1,0,1,0,0,1,0,1 in cycles t+1..t+8, then `outValid` at t+13 with `outData`=0xA5, and `busy`=0 from t+14.
- **Back-to-back:** hold `inValid` with 0x3C then 0xC3. Expect the second accept at t+9. Expect `outValid` at t+13 with 0x3C and at t+22 with 0xC3, and exactly 2 pulses in total.
- **Reset mid-word:** accept 0xFF, assert `rst` at t+5 for one cycle, then send 0x01. Expect no pulse carrying 0xFF, exactly one `outValid` with 0x01, and all outputs at their reset values during the cycle after the `rst` edge.
- **Handshake hold:** drive `inValid`=1 with changing data while `inReady`=0. Expect only the words present at `inReady`=1 edges to be transmitted.
- **Parameter sweep:** WIDTH=2 with DEPTH=1, and WIDTH=32 with DEPTH=16, using random words. Expect every word returned in order, each with latency WIDTH+DEPTH+1.
- **Idle:** 50 cycles with no `inValid`. Expect `serOut`=0, `outValid`=0 and `busy`=0 throughout.
